dmem_lsu: RTL
=============

DMEM_LSU -- requirements
Module: dmem_lsu

Interface
REQ-001 Parameter: ADDR_W, 16, number of low address bits backed by the four dmem byte lanes; any set bit in req_addr[31:ADDR_W] is out-of-range.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; asynchronous and active-high.
REQ-004 req_valid  input  1  pipeline load/store request.
REQ-005 req_ready  output  1  request accepted when req_valid && req_ready.
REQ-006 req_we  input  1  1 = store, 0 = load.
REQ-007 req_size  input  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-008 req_unsigned  input  1  load zero-extends (LBU/LHU) when 1, sign-extends when 0.
REQ-009 req_addr  input  32  byte address.
REQ-010 req_wdata  input  32  store data, right-aligned.
REQ-011 rsp_valid  output  1  one-cycle completion pulse.
REQ-012 rsp_rdata  output  32  aligned, extended load data; 0 for stores and errors.
REQ-013 rsp_err  output  1  qualified by rsp_valid; illegal size, out-of-range, or misaligned (see REQ-032).
REQ-014 mem_we  output  4  per-lane write enable; bit i drives byte lane i.
REQ-015 mem_addr  output  32  address to all lanes; equals req_addr.
REQ-016 mem_wdata  output  32  lane write data; bits [8i+7:8i] to lane i.
REQ-017 mem_rdata  input  32  concatenated lane read data; valid one cycle after the address edge.

Function
REQ-018 FSM states IDLE, LWAIT, RESP; req_ready = (state == IDLE).
REQ-019 Accept in cycle T: error-free store -> RESP; error-free load -> LWAIT; any error -> RESP with no memory access.
REQ-020 LWAIT -> RESP unconditionally; RESP -> IDLE unconditionally; rsp_valid = (state == RESP).
REQ-021 Latency: store/error rsp_valid at T+1; load rsp_valid at T+2; max throughput one store per 2 cycles, one load per 3.
REQ-022 mem_we is combinational, nonzero only in the accept cycle of an error-free store; 4'b0000 otherwise.
REQ-023 Byte store: mem_wdata = {4{req_wdata[7:0]}}, mem_we = 4'b0001 << addr[1:0].
REQ-024 Half store: mem_wdata = {2{req_wdata[15:0]}}, mem_we = addr[1] ? 4'b1100 : 4'b0011.
REQ-025 Word store: mem_wdata = req_wdata, mem_we = 4'b1111.
REQ-026 addr[1:0], size, unsigned registered at accept; load data captured from mem_rdata in LWAIT into rsp_rdata register.
REQ-027 Byte load: lane addr[1:0], bit 7 sign-extended unless unsigned; half load: lanes {3,2} if addr[1] else {1,0}, bit 15 extended; word load: mem_rdata unchanged.
REQ-028 rsp_rdata and rsp_err hold their value from RESP until next RESP; cleared to 0 when entering RESP for store or error-free condition respectively.
REQ-029 req_valid ignored outside IDLE; no request buffering; no response backpressure.

Reset
REQ-030 On rst (asynchronous): state = IDLE, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, registered addr/size/unsigned = 0; mem_we = 0 while rst high.
REQ-031 Reset in LWAIT or RESP aborts the access; no response is emitted for it.

Configuration
REQ-032 Macro DMEM_LSU_MISALIGN_EN: defined -> half with addr[0]=1 or word with addr[1:0]!=0 is an error (no write, rsp_err=1); undefined -> no misalignment error, half ignores addr[0], word ignores addr[1:0].

Verification
REQ-033 SW addr 0x100 data 0xDEADBEEF, then LW 0x100 -> mem_we 4'b1111 at T, store rsp at T+1, load rsp_rdata 0xDEADBEEF at T+2, rsp_err 0.
REQ-034 SB addr 0x103 data 0x80, then LB and LBU 0x103 -> mem_we 4'b1000; LB returns 0xFFFFFF80, LBU returns 0x00000080.
REQ-035 SH addr 0x202 data 0x8001, LH 0x202 -> mem_we 4'b1100; rsp_rdata 0xFFFF8001; LHU 0x200 returns untouched lower half.
REQ-036 LW addr 0x00010000 (ADDR_W=16) and req_size 11 -> mem_we stays 0, rsp_valid at T+1 with rsp_err 1, rsp_rdata 0.
REQ-037 SW addr 0x102: with DMEM_LSU_MISALIGN_EN rsp_err 1 and no write; without it mem_we 4'b1111 at word 0x100, rsp_err 0.
REQ-038 Assert rst during LWAIT -> state IDLE immediately, rsp_valid never pulses, req_ready 1 after release; req_valid held high during LWAIT is not accepted.

Source files
------------

// File: rtl/dmem_lsu.sv
// Load/store unit between a pipeline request port and four byte-lane data
// memories with a one-cycle synchronous read.
// Option: define DMEM_LSU_MISALIGN_EN to report misaligned half/word
// accesses as errors. Left undefined, the low address bits that a half or
// word access cannot use are ignored.
module dmem_lsu #(
  parameter int ADDR_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [3:0]  mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, LWAIT, RESP} state_t;

  state_t      state, state_nxt;
  logic        accept;
  logic        size_err, range_err, align_err, req_err;
  logic [3:0]  lane_we;
  logic [1:0]  addr_q;
  logic [1:0]  size_q;
  logic        unsigned_q;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_data;

  assign accept    = req_valid && (state == IDLE);
  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign mem_addr  = req_addr;

  assign size_err  = (req_size == 2'b11);
  assign range_err = |req_addr[31:ADDR_W];
`ifdef DMEM_LSU_MISALIGN_EN
  assign align_err = ((req_size == 2'b01) && req_addr[0]) ||
                     ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
`else
  assign align_err = 1'b0;
`endif
  assign req_err = size_err || range_err || align_err;

  // Replicate store data across the lanes and pick the lanes to write.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    lane_we   = 4'b0000;
    mem_wdata = req_wdata;
    case (req_size)
      2'b00: begin
        mem_wdata = {4{req_wdata[7:0]}};
        lane_we   = 4'b0001 << req_addr[1:0];
      end
      2'b01: begin
        mem_wdata = {2{req_wdata[15:0]}};
        lane_we   = req_addr[1] ? 4'b1100 : 4'b0011;
      end
      2'b10: lane_we = 4'b1111;
      default: lane_we = 4'b0000;
    endcase
  end

  // Lanes are written only in the accept cycle of an error-free store, never during reset.
  assign mem_we = (accept && req_we && !req_err && !rst) ? lane_we : 4'b0000;

  // Align and extend the lane data returned for the captured load.
  always_comb begin
    byte_sel  = mem_rdata[{addr_q, 3'b000} +: 8];
    half_sel  = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    load_data = mem_rdata;
    case (size_q)
      2'b00:   load_data = {{24{byte_sel[7] & ~unsigned_q}}, byte_sel};
      2'b01:   load_data = {{16{half_sel[15] & ~unsigned_q}}, half_sel};
      default: load_data = mem_rdata;
    endcase
  end

  // State register; reset aborts any access in flight.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state: stores and errors respond next cycle, loads wait one cycle for lane data.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (req_err || req_we) state_nxt = RESP;
          else                   state_nxt = LWAIT;
        end
      end
      LWAIT:   state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Capture request attributes at accept and the response payload for RESP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q     <= 2'b00;
      size_q     <= 2'b00;
      unsigned_q <= 1'b0;
      rsp_rdata  <= 32'h0;
      rsp_err    <= 1'b0;
    end else begin
      if (accept) begin
        addr_q     <= req_addr[1:0];
        size_q     <= req_size;
        unsigned_q <= req_unsigned;
        if (req_err || req_we) begin
          rsp_rdata <= 32'h0;
          rsp_err   <= req_err;
        end
      end
      if (state == LWAIT) begin
        rsp_rdata <= load_data;
        rsp_err   <= 1'b0;
      end
    end
  end

endmodule
